// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and command encodings for the SRAM/DRAM DMA
//               engine (state enum, command constants).
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

  // Engine states; FILL_WR is only reachable when DMA_FILL_EN is defined
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D2S_REQ = 3'd1,
    D2S_WR  = 3'd2,
    S2D_RD  = 3'd3,
    S2D_REQ = 3'd4,
    FILL_WR = 3'd5,
    DONE    = 3'd6
  } dma_state_t;

  localparam logic [1:0] DMA_CMD_NONE = 2'b00;
  localparam logic [1:0] DMA_CMD_D2S  = 2'b01;
  localparam logic [1:0] DMA_CMD_S2D  = 2'b10;
  localparam logic [1:0] DMA_CMD_FILL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/dma_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : dma_addr_counter
// Description : Remaining-word counter plus SRAM word pointer and DRAM byte
//               pointer. Load seeds all three; step consumes one word.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_addr_counter
  import dma_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int LEN_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [LEN_W-1:0]   i_rest,
  input  logic [SRAM_AW-1:0] i_sram_ptr,
  input  logic [31:0]        i_dram_ptr,
  output logic [SRAM_AW-1:0] o_sram_ptr,
  output logic [31:0]        o_dram_ptr,
  output logic               o_last
);

  logic [LEN_W-1:0]   r_rest;
  logic [SRAM_AW-1:0] r_sram_ptr;
  logic [31:0]        r_dram_ptr;

  // Load on command acceptance, otherwise advance one word per step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rest     <= '0;
      r_sram_ptr <= '0;
      r_dram_ptr <= '0;
    end else if (i_load) begin
      r_rest     <= i_rest;
      r_sram_ptr <= i_sram_ptr;
      r_dram_ptr <= i_dram_ptr;
    end else if (i_step) begin
      // Saturate at zero so a stray step can never wrap the count
      if (r_rest != '0) begin
        r_rest <= r_rest - LEN_W'(1);
      end
      r_sram_ptr <= r_sram_ptr + SRAM_AW'(1);
      r_dram_ptr <= r_dram_ptr + 32'd4;
    end
  end

  assign o_sram_ptr = r_sram_ptr;
  assign o_dram_ptr = r_dram_ptr;
  assign o_last     = (r_rest == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : dma_engine
// Description : Two-direction DMA between core SRAM and DRAM (DRAM->SRAM,
//               SRAM->DRAM) with done pulse and core stall. Optional SRAM
//               fill mode is built when the macro DMA_FILL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_engine
  import dma_pkg::*;
#(
  parameter int SRAM_AW = 14,
  parameter int LEN_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         cmd,
  input  logic [31:0]        srcAddress,
  input  logic [31:0]        dstAddress,
  input  logic [LEN_W-1:0]   width,
  input  logic [31:0]        sramReadData,
  output logic [SRAM_AW-1:0] sramAddress,
  output logic [31:0]        sramWriteData,
  output logic               sramWriteEnable,
  output logic [31:0]        dramAddress,
  output logic [31:0]        dramWriteData,
  output logic               dramReadEnable,
  output logic               dramWriteEnable,
  input  logic [31:0]        dramReadData,
  input  logic               dramValid,
  output logic               stall,
  output logic               done
);

  dma_state_t         r_state;
  dma_state_t         w_next;
  logic               r_stall;
  logic               r_done;
  logic               r_dram_re;
  logic               r_dram_we;
  logic               r_sram_we;
  logic               r_first;
  logic [31:0]        r_data;
  logic [31:0]        r_wdata;

  logic               w_cmd_d2s;
  logic               w_cmd_s2d;
  logic               w_cmd_fill;
  logic               w_cmd_valid;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [SRAM_AW-1:0] w_load_sram;
  logic [31:0]        w_load_dram;
  logic [SRAM_AW-1:0] w_sram_ptr;
  logic [31:0]        w_dram_ptr;
  logic               w_unused;

  assign w_cmd_d2s = (cmd == DMA_CMD_D2S);
  assign w_cmd_s2d = (cmd == DMA_CMD_S2D);
`ifdef DMA_FILL_EN
  assign w_cmd_fill = (cmd == DMA_CMD_FILL);
`else
  assign w_cmd_fill = 1'b0;
`endif
  assign w_cmd_valid = w_cmd_d2s | w_cmd_s2d | w_cmd_fill;

  // Only SRAM->DRAM reads SRAM at srcAddress; everything else writes SRAM at dstAddress
  assign w_load_sram = w_cmd_s2d ? srcAddress[SRAM_AW+1:2] : dstAddress[SRAM_AW+1:2];
  assign w_load_dram = w_cmd_s2d ? {dstAddress[31:2], 2'b00} : {srcAddress[31:2], 2'b00};
  assign w_unused    = ^{srcAddress[1:0], dstAddress[1:0]};

  assign w_load = (r_state == IDLE) & w_cmd_valid;
  assign w_step = (r_state == D2S_WR)
                | ((r_state == S2D_REQ) & dramValid)
                | (r_state == FILL_WR);

  dma_addr_counter #(
    .SRAM_AW (SRAM_AW),
    .LEN_W   (LEN_W)
  ) u_addr_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_rest     (width),
    .i_sram_ptr (w_load_sram),
    .i_dram_ptr (w_load_dram),
    .o_sram_ptr (w_sram_ptr),
    .o_dram_ptr (w_dram_ptr),
    .o_last     (w_last)
  );

  // Next-state selection; commands are only looked at in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_cmd_valid) begin
          if (width == '0)    w_next = DONE;
          else if (w_cmd_d2s) w_next = D2S_REQ;
          else if (w_cmd_s2d) w_next = S2D_RD;
          else                w_next = FILL_WR;
        end
      end
      D2S_REQ: if (dramValid) w_next = D2S_WR;
      D2S_WR:  w_next = w_last ? DONE : D2S_REQ;
      S2D_RD:  w_next = S2D_REQ;
      S2D_REQ: if (dramValid) w_next = w_last ? DONE : S2D_RD;
`ifdef DMA_FILL_EN
      FILL_WR: w_next = w_last ? DONE : FILL_WR;
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register with control outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_stall   <= 1'b0;
      r_done    <= 1'b0;
      r_dram_re <= 1'b0;
      r_dram_we <= 1'b0;
      r_sram_we <= 1'b0;
      r_first   <= 1'b0;
      r_data    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_stall   <= (w_next != IDLE);
      r_done    <= (w_next == DONE);
      r_dram_re <= (w_next == D2S_REQ);
      r_dram_we <= (w_next == S2D_REQ);
      r_sram_we <= (w_next == D2S_WR) || (w_next == FILL_WR);
      // r_first marks the first S2D_REQ cycle, when SRAM read data has just arrived
      r_first   <= (r_state == S2D_RD);
      if ((r_state == D2S_REQ) && dramValid) begin
        r_data <= dramReadData;
      end
`ifdef DMA_FILL_EN
      if (w_load && w_cmd_fill) begin
        r_data <= srcAddress;
      end
`endif
      if ((r_state == S2D_REQ) && r_first) begin
        r_wdata <= sramReadData;
      end
    end
  end

  // Write data follows the fresh SRAM word in the first cycle, then the held copy
  assign dramWriteData   = r_first ? sramReadData : r_wdata;
  assign sramWriteData   = r_data;
  assign sramAddress     = w_sram_ptr;
  assign dramAddress     = w_dram_ptr;
  assign sramWriteEnable = r_sram_we;
  assign dramReadEnable  = r_dram_re;
  assign dramWriteEnable = r_dram_we;
  assign stall           = r_stall;
  assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_engine
// Description : Self-checking bench for dma_engine with SRAM/DRAM models and
//               a transfer-level reference model. Honours DMA_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_engine;

  localparam int SRAM_AW = 14;
  localparam int LEN_W   = 10;
  localparam int SRAM_N  = 1 << SRAM_AW;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         cmd;
  logic [31:0]        srcAddress, dstAddress;
  logic [LEN_W-1:0]   width;
  logic [31:0]        sramReadData;
  logic [SRAM_AW-1:0] sramAddress;
  logic [31:0]        sramWriteData;
  logic               sramWriteEnable;
  logic [31:0]        dramAddress, dramWriteData;
  logic               dramReadEnable, dramWriteEnable;
  logic [31:0]        dramReadData;
  logic               dramValid;
  logic               stall, done;

  int n_checks = 0;
  int n_errors = 0;
  int lat_cfg  = 0;
  int wcnt     = 0;
  logic [SRAM_AW-1:0] rd_addr = '0;
  logic [31:0] sram     [SRAM_N];
  logic [31:0] ref_sram [SRAM_N];

  always #5 clk = ~clk;

  dma_engine #(.SRAM_AW(SRAM_AW), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .srcAddress(srcAddress), .dstAddress(dstAddress),
    .width(width), .sramReadData(sramReadData), .sramAddress(sramAddress),
    .sramWriteData(sramWriteData), .sramWriteEnable(sramWriteEnable),
    .dramAddress(dramAddress), .dramWriteData(dramWriteData),
    .dramReadEnable(dramReadEnable), .dramWriteEnable(dramWriteEnable),
    .dramReadData(dramReadData), .dramValid(dramValid), .stall(stall), .done(done)
  );

  function automatic logic [31:0] dram_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory models: synchronous-read SRAM and a DRAM with configurable wait
  always @(negedge clk) begin
    sramReadData = sram[rd_addr];
    if (sramWriteEnable) sram[sramAddress] = sramWriteData;
    rd_addr = sramAddress;
    if (!(dramReadEnable || dramWriteEnable)) begin
      dramValid    = 1'b0;
      wcnt         = 0;
      dramReadData = $urandom;
    end else begin
      dramValid    = (wcnt >= lat_cfg);
      wcnt++;
      dramReadData = (dramValid && dramReadEnable) ? dram_word(dramAddress) : $urandom;
    end
  end

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_stall"}, stall, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_enables"}, {dramReadEnable, dramWriteEnable, sramWriteEnable}, 0);
    check({pfx, "_sram_addr"}, sramAddress, 0);
    check({pfx, "_sram_wdata"}, sramWriteData, 0);
    check({pfx, "_dram_addr"}, dramAddress, 0);
    check({pfx, "_dram_wdata"}, dramWriteData, 0);
  endtask

  // One transfer: build expected write list, drive, observe, compare
  task automatic run_xfer(input logic [1:0] c, input logic [31:0] src, input logic [31:0] dst,
                          input int w, input int lat);
    int exp_busy, exp_en, stall_cyc, en_cyc, dones, cyc;
    bit fin, unstable, overlap, prev_we;
    logic [31:0] first_a, first_d, da;
    logic [SRAM_AW-1:0] sa;
    logic [31:0] ea[$], ed[$], ga[$], gd[$];
    lat_cfg = lat;
    for (int i = 0; i < w; i++) begin
      if (c == 2'b01) begin
        da = src + 32'(4 * i);
        da[1:0] = 2'b00;
        sa = dst[SRAM_AW+1:2] + SRAM_AW'(i);
        ea.push_back(32'(sa)); ed.push_back(dram_word(da));
        ref_sram[sa] = dram_word(da);
      end else if (c == 2'b10) begin
        sa = src[SRAM_AW+1:2] + SRAM_AW'(i);
        da = {dst[31:2], 2'b00} + 32'(4 * i);
        ea.push_back(da); ed.push_back(ref_sram[sa]);
      end else begin
        sa = dst[SRAM_AW+1:2] + SRAM_AW'(i);
        ea.push_back(32'(sa)); ed.push_back(src);
        ref_sram[sa] = src;
      end
    end
    exp_busy = (c == 2'b11) ? w : w * (2 + lat);
    exp_en   = (c == 2'b01) ? w * (2 + lat) : (c == 2'b10) ? w * (1 + lat) : w;
    stall_cyc = 0; en_cyc = 0; dones = 0; cyc = 0;
    fin = 0; unstable = 0; overlap = 0; prev_we = 0;
    first_a = '0; first_d = '0;

    @(negedge clk); #1;
    cmd = c; srcAddress = src; dstAddress = dst; width = LEN_W'(w);
    while (!fin) begin
      @(negedge clk); #1;
      cyc++;
      if (stall) stall_cyc++;
      if (done) begin
        dones++;
        if (dramReadEnable || dramWriteEnable || sramWriteEnable) overlap = 1;
      end
      if (dramReadEnable || dramWriteEnable || sramWriteEnable) en_cyc++;
      if (dramReadEnable && dramWriteEnable) overlap = 1;
      if (sramWriteEnable) begin
        ga.push_back(32'(sramAddress)); gd.push_back(sramWriteData);
      end
      if (dramWriteEnable) begin
        if (!prev_we) begin
          first_a = dramAddress; first_d = dramWriteData;
        end else if (dramAddress !== first_a || dramWriteData !== first_d) begin
          unstable = 1;
        end
        if (dramValid) begin
          ga.push_back(dramAddress); gd.push_back(dramWriteData);
        end
      end
      prev_we = dramWriteEnable;
      if (done || !stall) begin
        cmd = 2'b00;
      end else begin
        cmd = 2'($urandom_range(0, 3));
        srcAddress = $urandom; dstAddress = $urandom; width = LEN_W'($urandom);
      end
      if (!stall) fin = 1;
      else if (cyc > 2000) begin
        check("xfer_timeout", cyc, 0);
        fin = 1;
      end
    end
    check("busy_cycles", stall_cyc, exp_busy + 1);
    check("done_pulses", dones, 1);
    check("enable_cycles", en_cyc, exp_en);
    check("enable_overlap", overlap, 0);
    check("dram_wr_stable", unstable, 0);
    check("write_count", ga.size(), ea.size());
    for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
      check("write_addr", ga[i], ea[i]);
      check("write_data", gd[i], ed[i]);
    end
  endtask

  initial begin
    reset = 1'b1; cmd = 2'b00; srcAddress = '0; dstAddress = '0; width = '0;
    sramReadData = '0; dramReadData = '0; dramValid = 1'b0;
    for (int i = 0; i < SRAM_N; i++) begin
      sram[i] = $urandom;
      ref_sram[i] = sram[i];
    end
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Directed cases
    run_xfer(2'b01, 32'h0000_1000, 32'h0000_0040, 3, 0);
    run_xfer(2'b10, 32'h0000_0040, 32'h0000_2000, 2, 3);
    run_xfer(2'b01, 32'h0000_3000, 32'h0000_0080, 0, 0);
    run_xfer(2'b01, 32'h0000_5000, 32'h0000_FFFC, 2, 1);

    // Reset while the DRAM read request is outstanding
    @(negedge clk); #1;
    lat_cfg = 6;
    cmd = 2'b01; srcAddress = 32'h0000_0100; dstAddress = 32'h0000_0200; width = LEN_W'(4);
    @(negedge clk); #1;
    cmd = 2'b00;
    check("rst_mid_req", dramReadEnable, 1);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check_idle_outputs("rst_mid");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_mid_no_done", {stall, done}, 0);
    end

`ifdef DMA_FILL_EN
    run_xfer(2'b11, 32'hDEAD_BEEF, 32'h0000_0300, 4, 0);
`else
    @(negedge clk); #1;
    cmd = 2'b11; srcAddress = 32'hDEAD_BEEF; dstAddress = 32'h0000_0300; width = LEN_W'(4);
    repeat (4) begin
      @(negedge clk); #1;
      check("nofill_idle", {stall, done, dramReadEnable, dramWriteEnable, sramWriteEnable}, 0);
    end
    cmd = 2'b00;
`endif

    // Randomized transfers
    for (int t = 0; t < 24; t++) begin
      logic [1:0] c;
`ifdef DMA_FILL_EN
      c = 2'($urandom_range(1, 3));
`else
      c = 2'($urandom_range(1, 2));
`endif
      run_xfer(c, $urandom, $urandom, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
